// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM encodings and byte geometry.
package fetch_prefetch_queue_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FPQ_HALT  = 2'd0,
    FPQ_FETCH = 2'd1,
    FPQ_WAIT  = 2'd2,
    FPQ_DRAIN = 2'd3
  } fpq_state_e;

  // Bytes of a fetched word that land in the queue, given the leading bytes to skip.
  function automatic logic [2:0] word_push_count(input logic [1:0] skip);
    return 3'd4 - {1'b0, skip};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_byte_queue.sv
// Circular byte buffer: pushes 1-4 bytes, pops 0-WIN bytes and exposes a WIN-byte
// read window that is zero beyond the current occupancy.
module fetch_prefetch_queue_byte_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIN   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        push,
  input  logic [2:0]                  push_count,
  input  logic [31:0]                 push_data,
  input  logic [3:0]                  pop_req,
  output logic [3:0]                  pop_count,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [3:0]                  win_count,
  output logic [BYTE_W*WIN-1:0]       win_bytes
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WIN_OCC = (AW+1)'(WIN);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW:0]       occ_r;

  assign occupancy = occ_r;
  assign win_count = (occ_r >= WIN_OCC) ? 4'(WIN) : 4'(occ_r);
  assign pop_count = (pop_req > win_count) ? win_count : pop_req;

  // window assembly straight from the storage registers
  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WIN; i++) begin
      if ((AW+1)'(i) < occ_r) begin
        win_bytes[BYTE_W*i +: BYTE_W] = mem_r[rd_ptr_r + AW'(i)];
      end else begin
        win_bytes[BYTE_W*i +: BYTE_W] = 8'h00;
      end
    end
  end

  // byte storage; contents beyond occupancy are masked so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < push_count) begin
          mem_r[wr_ptr_r + AW'(i)] <= push_data[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  // pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + (push ? AW'(push_count) : AW'(0));
      rd_ptr_r <= rd_ptr_r + AW'(pop_count);
      occ_r    <= occ_r + (push ? (AW+1)'(push_count) : (AW+1)'(0)) - (AW+1)'(pop_count);
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: single-outstanding aligned word reads feeding a byte
// queue, with redirect (fetch_load) and flush handling including stale-response drain.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter int          WIN           = 8,
  parameter logic [31:0] RESET_ADDRESS = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_fetch,
  input  logic                  fetch_load,
  input  logic [31:0]           fetch_load_address,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [31:0]           mem_address,
  input  logic                  mem_dp_valid,
  output logic                  mem_dp_ready,
  input  logic [31:0]           mem_dp_read_data,
  output logic                  dec_valid,
  output logic [BYTE_W*WIN-1:0] dec_bytes,
  output logic [3:0]            dec_count,
  output logic [31:0]           dec_pc,
  input  logic [3:0]            dec_consume
);

  localparam int AW = $clog2(DEPTH);

  fpq_state_e    state_r;
  fpq_state_e    state_s;
  logic          stale_r;
  logic          stale_s;
  logic [31:0]   fetch_addr_r;
  logic [1:0]    skip_r;
  logic [31:0]   dec_pc_r;
  logic          redirect_s;
  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          in_flight_s;
  logic          room_s;
  logic          push_s;
  logic [31:0]   push_data_s;
  logic [3:0]    pop_req_s;
  logic [3:0]    pop_count_s;
  logic [AW:0]   occupancy_s;

  assign redirect_s  = fetch_load | flush_fetch;
  assign req_fire_s  = mem_valid & mem_ready;
  assign rsp_fire_s  = mem_dp_valid & mem_dp_ready;
  // a read is still owed to us after this edge if accepted now or pending and not returning now
  assign in_flight_s = (((state_r == FPQ_WAIT) || (state_r == FPQ_DRAIN)) && !rsp_fire_s) || req_fire_s;
  assign room_s      = occupancy_s <= (AW+1)'(DEPTH - 4);
  assign push_s      = (state_r == FPQ_WAIT) && rsp_fire_s && !redirect_s;
  assign push_data_s = mem_dp_read_data >> {skip_r, 3'b000};
  assign pop_req_s   = redirect_s ? 4'd0 : dec_consume;

  fetch_prefetch_queue_byte_queue #(.DEPTH(DEPTH), .WIN(WIN)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_s),
    .push       (push_s),
    .push_count (word_push_count(skip_r)),
    .push_data  (push_data_s),
    .pop_req    (pop_req_s),
    .pop_count  (pop_count_s),
    .occupancy  (occupancy_s),
    .win_count  (dec_count),
    .win_bytes  (dec_bytes)
  );

  assign dec_valid   = dec_count != 4'd0;
  assign dec_pc      = dec_pc_r;
  assign mem_address = fetch_addr_r;

  // state register; stale_r selects FETCH (1) or HALT (0) once a drain completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= FPQ_FETCH;
      stale_r <= 1'b0;
    end else begin
      state_r <= state_s;
      stale_r <= stale_s;
    end
  end

  // next-state logic; fetch_load takes priority over flush_fetch
  always_comb begin
    state_s = state_r;
    stale_s = stale_r;
    if (fetch_load) begin
      state_s = in_flight_s ? FPQ_DRAIN : FPQ_FETCH;
      stale_s = 1'b1;
    end else if (flush_fetch) begin
      state_s = in_flight_s ? FPQ_DRAIN : FPQ_HALT;
      stale_s = 1'b0;
    end else begin
      case (state_r)
        FPQ_FETCH: state_s = req_fire_s ? FPQ_WAIT : FPQ_FETCH;
        FPQ_WAIT:  state_s = rsp_fire_s ? FPQ_FETCH : FPQ_WAIT;
        FPQ_DRAIN: state_s = rsp_fire_s ? (stale_r ? FPQ_FETCH : FPQ_HALT) : FPQ_DRAIN;
        FPQ_HALT:  state_s = FPQ_HALT;
        default:   state_s = FPQ_FETCH;
      endcase
    end
  end

  // memory handshake outputs, silenced while reset is held
  always_comb begin
    mem_valid    = 1'b0;
    mem_dp_ready = 1'b0;
    case (state_r)
      FPQ_FETCH: mem_valid    = reset & room_s;
      FPQ_WAIT:  mem_dp_ready = reset;
      FPQ_DRAIN: mem_dp_ready = reset;
      FPQ_HALT:  mem_valid    = 1'b0;
      default:   mem_valid    = 1'b0;
    endcase
  end

  // fetch address, alignment skip and decode pc
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_addr_r <= RESET_ADDRESS & 32'hFFFF_FFFC;
      skip_r       <= RESET_ADDRESS[1:0];
      dec_pc_r     <= RESET_ADDRESS;
    end else if (fetch_load) begin
      fetch_addr_r <= fetch_load_address & 32'hFFFF_FFFC;
      skip_r       <= fetch_load_address[1:0];
      dec_pc_r     <= fetch_load_address;
    end else if (flush_fetch) begin
      fetch_addr_r <= fetch_addr_r;
      skip_r       <= skip_r;
      dec_pc_r     <= dec_pc_r;
    end else begin
      if (push_s) begin
        fetch_addr_r <= fetch_addr_r + 32'd4;
        skip_r       <= 2'd0;
      end
      dec_pc_r <= dec_pc_r + 32'(pop_count_s);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: memory responder model, expected address and
// byte queues refilled on each redirect, per-cycle window / handshake checks.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RST_ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, flush_fetch, fetch_load;
  logic [31:0] fetch_load_address;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_address;
  logic        mem_dp_valid, mem_dp_ready;
  logic [31:0] mem_dp_read_data;
  logic        dec_valid;
  logic [63:0] dec_bytes;
  logic [3:0]  dec_count;
  logic [31:0] dec_pc;
  logic [3:0]  dec_consume;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(16), .WIN(8), .RESET_ADDRESS(RST_ADDR)) dut (
    .clk(clk), .reset(reset), .flush_fetch(flush_fetch), .fetch_load(fetch_load),
    .fetch_load_address(fetch_load_address), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_address(mem_address), .mem_dp_valid(mem_dp_valid), .mem_dp_ready(mem_dp_ready),
    .mem_dp_read_data(mem_dp_read_data), .dec_valid(dec_valid), .dec_bytes(dec_bytes),
    .dec_count(dec_count), .dec_pc(dec_pc), .dec_consume(dec_consume)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0]  tweak;
    logic [31:0] w;
    if (a == 32'h0000_2000) return 32'hAABB_CCDD;
    tweak = {a[15:12] - 4'd1, 4'h0};
    for (int i = 0; i < 4; i++) w[8*i +: 8] = (a[7:0] + 8'(i)) ^ tweak;
    return w;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // model state
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [31:0] exp_pc;
  int          exp_occ, exp_skip;
  bit          halted, rsp_pending, rsp_stale;
  logic [31:0] rsp_addr;
  int          rsp_delay, lat_cfg, req_count;
  bit          ready_hold;
  logic [3:0]  cons_val;

  task automatic expect_from(input logic [31:0] a);
    exp_addr_q.delete();
    exp_byte_q.delete();
    for (int k = 0; k < 40; k++) exp_addr_q.push_back({a[31:2], 2'b00} + 32'(4*k));
    for (int k = 0; k < 160; k++) exp_byte_q.push_back(ref_byte(a + 32'(k)));
    exp_pc   = a;
    exp_skip = int'(a[1:0]);
  endtask

  task automatic observe();
    bit ld, fl, req, rsp;
    int win, k;
    ld  = fetch_load;
    fl  = flush_fetch;
    req = mem_valid && mem_ready;
    rsp = mem_dp_valid && mem_dp_ready;
    if (!reset) begin
      check_eq("mem_valid_in_reset", 64'(mem_valid), 64'd0);
      rsp_pending = 0; rsp_stale = 0; exp_occ = 0; halted = 0; req_count = 0;
      expect_from(RST_ADDR);
      return;
    end
    win = (exp_occ < 8) ? exp_occ : 8;
    check_eq("dec_count", 64'(dec_count), 64'(win));
    check_eq("dec_valid", 64'(dec_valid), 64'(win != 0));
    check_eq("dec_pc", 64'(dec_pc), 64'(exp_pc));
    for (int i = 0; i < 8; i++) begin
      if (i < win && i < exp_byte_q.size()) check_eq("dec_byte", 64'(dec_bytes[8*i +: 8]), 64'(exp_byte_q[i]));
      else if (i >= win) check_eq("dec_pad", 64'(dec_bytes[8*i +: 8]), 64'd0);
    end
    check_eq("mem_valid", 64'(mem_valid), 64'(!halted && !rsp_pending && exp_occ <= 12));
    check_eq("mem_dp_ready", 64'(mem_dp_ready), 64'(rsp_pending));
    if (mem_valid && exp_addr_q.size() != 0) check_eq("mem_address", 64'(mem_address), 64'(exp_addr_q[0]));
    // responder and occupancy model advance to the next edge
    if (rsp_pending && !rsp && rsp_delay > 0) rsp_delay--;
    if (rsp) begin
      if (!rsp_stale && !ld && !fl) begin
        exp_occ += 4 - exp_skip;
        exp_skip = 0;
      end
      rsp_pending = 0;
      rsp_stale   = 0;
    end
    if (req) begin
      if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      rsp_pending = 1;
      rsp_addr    = mem_address;
      rsp_delay   = lat_cfg;
      req_count++;
    end
    if (ld || fl) begin
      if (rsp_pending) rsp_stale = 1;
      exp_occ = 0;
      if (ld) begin
        halted = 0;
        expect_from(fetch_load_address);
      end else begin
        halted = 1;
        exp_addr_q.delete();
        exp_byte_q.delete();
      end
    end else begin
      k = (int'(cons_val) < win) ? int'(cons_val) : win;
      for (int j = 0; j < k; j++) if (exp_byte_q.size() != 0) void'(exp_byte_q.pop_front());
      exp_pc  = exp_pc + 32'(k);
      exp_occ = exp_occ - k;
    end
  endtask

  task automatic cycle();
    mem_ready        = !ready_hold;
    dec_consume      = cons_val;
    mem_dp_valid     = rsp_pending && rsp_delay == 0;
    mem_dp_read_data = rsp_pending ? mem_word(rsp_addr) : 32'h0;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit ld, input bit fl, input logic [31:0] a);
    fetch_load = ld; flush_fetch = fl; fetch_load_address = a;
    cycle();
    fetch_load = 1'b0; flush_fetch = 1'b0;
  endtask

  task automatic wait_pending(input logic [31:0] a, input int lim);
    int n = 0;
    while (!(rsp_pending && rsp_addr == a) && n < lim) begin cycle(); n++; end
    check_eq("wait_pending", 64'(rsp_pending && rsp_addr == a), 64'd1);
  endtask

  initial begin
    reset = 1'b0; flush_fetch = 1'b0; fetch_load = 1'b0; fetch_load_address = 32'h0;
    mem_ready = 1'b0; mem_dp_valid = 1'b0; mem_dp_read_data = 32'h0; dec_consume = 4'd0;
    rsp_pending = 0; rsp_stale = 0; halted = 0; exp_occ = 0; lat_cfg = 1; req_count = 0;
    ready_hold = 0; cons_val = 4'd0; rsp_delay = 0; rsp_addr = 32'h0;
    expect_from(RST_ADDR);
    @(posedge clk); #1;
    repeat (2) cycle();
    reset = 1'b1;

    // fill after reset with no consumption
    repeat (30) cycle();
    check_eq("t1_reads", 64'(req_count), 64'd4);
    check_eq("t1_window", dec_bytes, 64'h0706_0504_0302_0100);
    check_eq("t1_count", 64'(dec_count), 64'd8);
    check_eq("t1_idle", 64'(mem_valid), 64'd0);

    // unaligned redirect
    pulse(1'b1, 1'b0, 32'h0000_2003);
    check_eq("t2_first_addr", 64'(mem_address), 64'h2000);
    repeat (4) cycle();
    check_eq("t2_pc", 64'(dec_pc), 64'h2003);
    check_eq("t2_byte0", 64'(dec_bytes[7:0]), 64'hAA);
    cons_val = 4'd3;
    repeat (20) cycle();

    // redirect while a read is outstanding
    cons_val = 4'd0; lat_cfg = 3;
    pulse(1'b1, 1'b0, 32'h0000_1000);
    wait_pending(32'h0000_1004, 40);
    pulse(1'b1, 1'b0, 32'h0000_3000);
    check_eq("t3_drain_idle", 64'(mem_valid), 64'd0);
    cons_val = 4'd2;
    repeat (25) cycle();

    // redirect in the same cycle a request is accepted
    begin
      int n = 0;
      while (!mem_valid && n < 40) begin cycle(); n++; end
      check_eq("t3b_req_seen", 64'(mem_valid), 64'd1);
    end
    pulse(1'b1, 1'b0, 32'h0000_5001);
    check_eq("t3b_drain_idle", 64'(mem_valid), 64'd0);
    repeat (15) cycle();

    // full queue, consume 3 per cycle with immediate responses
    lat_cfg = 0; cons_val = 4'd0;
    pulse(1'b1, 1'b0, 32'h0000_1000);
    begin
      int n = 0;
      while (exp_occ != 16 && n < 80) begin cycle(); n++; end
      check_eq("t4_full", 64'(dec_count), 64'd8);
      check_eq("t4_full_idle", 64'(mem_valid), 64'd0);
    end
    cons_val = 4'd3;
    repeat (12) cycle();

    // load and flush together, then flush alone
    cons_val = 4'd1;
    pulse(1'b1, 1'b1, 32'h0000_4000);
    check_eq("t5_load_wins", 64'(mem_address), 64'h4000);
    repeat (10) cycle();
    pulse(1'b0, 1'b1, 32'h0);
    repeat (20) cycle();
    check_eq("t5_halted", 64'(mem_valid), 64'd0);
    pulse(1'b1, 1'b0, 32'h0000_6002);
    repeat (10) cycle();

    // address wrap past 2^32
    cons_val = 4'd2; lat_cfg = 1;
    pulse(1'b1, 1'b0, 32'hFFFF_FFFA);
    repeat (30) cycle();

    // stalled request, then reset mid-WAIT
    cons_val = 4'd0; ready_hold = 1;
    pulse(1'b1, 1'b0, 32'h0000_7000);
    repeat (6) cycle();
    check_eq("t6_stall_valid", 64'(mem_valid), 64'd1);
    check_eq("t6_stall_addr", 64'(mem_address), 64'h7000);
    ready_hold = 0; lat_cfg = 3;
    wait_pending(32'h0000_7000, 10);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_eq("t6_rst_addr", 64'(mem_address), 64'(RST_ADDR));
    check_eq("t6_rst_count", 64'(dec_count), 64'd0);
    check_eq("t6_rst_pc", 64'(dec_pc), 64'(RST_ADDR));
    cons_val = 4'd4;
    repeat (30) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
